// File: rtl/jt12_mod_hist.sv
// Operator output history for the FM pipeline. It records every operator result
// and builds the phase-modulation term for the slot entering the phase stage.
// The term is taken from the x/y sources chosen by the algorithm decoder.
// For S1 the term is scaled by the self-feedback level.
module jt12_mod_hist #(
  parameter int num_ch = 6,
  parameter int W      = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic signed [W-1:0] op_result,
  input  logic [1:0]          op_id,
  input  logic                s1_enters,
  input  logic                xuse_prevprev1,
  input  logic                xuse_prev2,
  input  logic                xuse_internal,
  input  logic                yuse_prev1,
  input  logic                yuse_prev2,
  input  logic                yuse_internal,
  input  logic [2:0]          fb,
  output logic signed [W:0]   mod_out,
  output logic                sel_err
);

  localparam int HD = 2 * num_ch;

  // all operator results, one entry per slot
  logic signed [W-1:0] hist    [HD];
  // per-operator recirculating lines: S1, S2, S3
  logic signed [W-1:0] line_s1 [num_ch];
  logic signed [W-1:0] line_s2 [num_ch];
  logic signed [W-1:0] line_s3 [num_ch];

  logic signed [W-1:0] prev1, prevprev1, prev2, int_x, int_y;
  logic signed [W-1:0] x_sel_p0, y_sel_p0;
  logic signed [W:0]   sum_p0, mod_p0;
  logic                over_p0;

  // true when at least two of the three selects are high
  function automatic logic multi_sel(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // S1 feedback scaling: level 7 passes the sum through, each lower level halves it
  function automatic logic signed [W:0] fb_scale(input logic signed [W:0] s,
                                                 input logic [2:0] lvl);
    logic signed [W:0] r;
    if (lvl == 3'd0) r = '0;
    else             r = s >>> (3'd7 - lvl);
    return r;
  endfunction

  // every read is taken from the pre-shift contents
  assign prev1     = hist[num_ch-1];
  assign prevprev1 = hist[HD-1];
  assign int_x     = line_s1[num_ch-1];
  assign prev2     = line_s2[num_ch-1];
  assign int_y     = line_s3[num_ch-1];

  // stage p0: priority source selection, full-width sum and feedback scaling
  always_comb begin
    x_sel_p0 = '0;
    y_sel_p0 = '0;
    if (xuse_prevprev1)     x_sel_p0 = prevprev1;
    else if (xuse_prev2)    x_sel_p0 = prev2;
    else if (xuse_internal) x_sel_p0 = int_x;
    if (yuse_prev1)         y_sel_p0 = prev1;
    else if (yuse_prev2)    y_sel_p0 = prev2;
    else if (yuse_internal) y_sel_p0 = int_y;
    sum_p0  = {x_sel_p0[W-1], x_sel_p0} + {y_sel_p0[W-1], y_sel_p0};
    mod_p0  = s1_enters ? fb_scale(sum_p0, fb) : sum_p0;
    over_p0 = multi_sel(xuse_prevprev1, xuse_prev2, xuse_internal) |
              multi_sel(yuse_prev1, yuse_prev2, yuse_internal);
  end

  // history shift line: newest result enters at the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HD; k++) hist[k] <= '0;
    end else if (clk_en) begin
      hist[0] <= op_result;
      for (int k = 1; k < HD; k++) hist[k] <= hist[k-1];
    end
  end

  // operator lines rotate every slot; a matching op_id replaces the tail that wraps to the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < num_ch; k++) begin
        line_s1[k] <= '0;
        line_s2[k] <= '0;
        line_s3[k] <= '0;
      end
    end else if (clk_en) begin
      line_s1[0] <= (op_id == 2'd0) ? op_result : line_s1[num_ch-1];
      line_s3[0] <= (op_id == 2'd1) ? op_result : line_s3[num_ch-1];
      line_s2[0] <= (op_id == 2'd2) ? op_result : line_s2[num_ch-1];
      for (int k = 1; k < num_ch; k++) begin
        line_s1[k] <= line_s1[k-1];
        line_s2[k] <= line_s2[k-1];
        line_s3[k] <= line_s3[k-1];
      end
    end
  end

  // stage p0 -> output: register the modulation term and the sticky select error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_out <= '0;
      sel_err <= 1'b0;
    end else if (clk_en) begin
      mod_out <= mod_p0;
      if (over_p0) sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt12_mod_hist.sv
// Scoreboard bench for jt12_mod_hist. The stimulus side queues the hand-derived
// result of each enabled slot. A monitor compares the queued result after every
// consuming clock edge.
module tb_jt12_mod_hist;
  localparam int W = 14;
  localparam logic [2:0] XPP = 3'b100, XP2 = 3'b010, XIN = 3'b001;
  localparam logic [2:0] YP1 = 3'b100, YP2 = 3'b010, YIN = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic signed [W-1:0] op_result = '0;
  logic [1:0] op_id = 2'd3;
  logic s1_enters = 1'b0;
  logic xuse_prevprev1 = 1'b0, xuse_prev2 = 1'b0, xuse_internal = 1'b0;
  logic yuse_prev1 = 1'b0, yuse_prev2 = 1'b0, yuse_internal = 1'b0;
  logic [2:0] fb = 3'd0;
  logic signed [W:0] mod_out;
  logic sel_err;

  jt12_mod_hist #(.num_ch(6), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .op_result(op_result), .op_id(op_id), .s1_enters(s1_enters),
    .xuse_prevprev1(xuse_prevprev1), .xuse_prev2(xuse_prev2), .xuse_internal(xuse_internal),
    .yuse_prev1(yuse_prev1), .yuse_prev2(yuse_prev2), .yuse_internal(yuse_internal),
    .fb(fb), .mod_out(mod_out), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [W:0] m;
    logic              e;
    logic [7:0]        sec;
    logic [15:0]       idx;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int sec = 0;
  int idx = 0;
  logic err_exp = 1'b0;
  logic mon_en;
  exp_t mon_e;

  function automatic logic multi(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  task automatic check_now(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  // one enabled slot with its expected registered result
  task automatic slot(input logic signed [W-1:0] res, input logic [1:0] id, input logic s1,
                      input logic [2:0] xs, input logic [2:0] ys, input logic [2:0] f,
                      input logic signed [W:0] em);
    exp_t e;
    @(negedge clk);
    op_result = res; op_id = id; s1_enters = s1; fb = f;
    {xuse_prevprev1, xuse_prev2, xuse_internal} = xs;
    {yuse_prev1, yuse_prev2, yuse_internal} = ys;
    clk_en = 1'b1;
    if (multi(xs) || multi(ys)) err_exp = 1'b1;
    e.m = em; e.e = err_exp; e.sec = 8'(sec); e.idx = 16'(idx);
    sb.push_back(e);
    idx++;
    @(posedge clk);
  endtask

  // disabled slot with garbage on every input
  task automatic idle();
    @(negedge clk);
    clk_en = 1'b0;
    op_result = 14'sh1555; op_id = 2'd2; s1_enters = 1'b1; fb = 3'd7;
    {xuse_prevprev1, xuse_prev2, xuse_internal} = 3'b111;
    {yuse_prev1, yuse_prev2, yuse_internal} = 3'b111;
    @(posedge clk);
  endtask

  // asynchronous reset between edges, checked before any clock edge
  task automatic reset_check(input string tag);
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_now({tag, " mod_out async"}, int'(mod_out), 0);
    check_now({tag, " sel_err async"}, int'(sel_err), 0);
    err_exp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: pops one expectation per consumed slot
  initial begin
    forever begin
      @(posedge clk);
      mon_en = clk_en & rst_n;
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard underflow got output want none");
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (mod_out !== mon_e.m) begin
            errors++;
            $display("FAIL sec%0d slot%0d mod_out got %0d want %0d",
                     mon_e.sec, mon_e.idx, mod_out, $signed(mon_e.m));
          end
          checks++;
          if (sel_err !== mon_e.e) begin
            errors++;
            $display("FAIL sec%0d slot%0d sel_err got %0d want %0d",
                     mon_e.sec, mon_e.idx, sel_err, mon_e.e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset at power-up
    #12;
    check_now("power-up mod_out", int'(mod_out), 0);
    check_now("power-up sel_err", int'(sel_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // prev1 delay of 6 slots
    sec = 1; idx = 0;
    for (int k = 0; k < 14; k++)
      slot((k == 0) ? 14'sd100 : 14'sd0, 2'd3, 1'b0, 3'b000, YP1, 3'd0, (k == 6) ? 15'sd100 : 15'sd0);

    // prevprev1 delay of 12 slots
    sec = 2; idx = 0;
    for (int k = 0; k < 18; k++)
      slot((k == 0) ? 14'sd100 : 14'sd0, 2'd3, 1'b0, XPP, 3'b000, 3'd0, (k == 12) ? 15'sd100 : 15'sd0);

    // S2 recirculation, then the same with clk_en toggling
    sec = 3; idx = 0;
    for (int k = 0; k < 25; k++)
      slot((k == 0) ? -14'sd500 : 14'sd0, (k == 0) ? 2'd2 : 2'd3, 1'b0, XP2, 3'b000, 3'd0,
           (k > 0 && k % 6 == 0) ? -15'sd500 : 15'sd0);
    for (int k = 25; k < 49; k++) begin
      idle();
      slot(14'sd0, 2'd3, 1'b0, XP2, 3'b000, 3'd0, (k % 6 == 0) ? -15'sd500 : 15'sd0);
    end

    // mid-frame reset wipes all history
    reset_check("midframe");
    sec = 4; idx = 0;
    for (int k = 0; k < 12; k++) begin
      logic [2:0] xs, ys;
      case (k % 3)
        0:       begin xs = XPP; ys = YP1; end
        1:       begin xs = XP2; ys = YP2; end
        default: begin xs = XIN; ys = YIN; end
      endcase
      slot(14'sd0, 2'd3, 1'b0, xs, ys, 3'd0, 15'sd0);
    end

    // S1 feedback scaling
    sec = 5; idx = 0;
    for (int k = 0; k < 12; k++) slot(14'sd4096, 2'd3, 1'b0, 3'b000, 3'b000, 3'd0, 15'sd0);
    slot(14'sd4096, 2'd3, 1'b1, XPP, YP1, 3'd7, 15'sd8192);
    slot(14'sd4096, 2'd3, 1'b1, XPP, YP1, 3'd1, 15'sd128);
    slot(14'sd4096, 2'd3, 1'b1, XPP, YP1, 3'd0, 15'sd0);
    slot(14'sd4096, 2'd3, 1'b1, XPP, YP1, 3'd4, 15'sd1024);
    slot(14'sd4096, 2'd3, 1'b0, XPP, YP1, 3'd3, 15'sd8192);
    for (int k = 0; k < 6; k++) slot(-14'sd4096, 2'd3, 1'b0, 3'b000, 3'b000, 3'd0, 15'sd0);
    for (int k = 0; k < 6; k++) slot(-14'sd4095, 2'd3, 1'b0, 3'b000, 3'b000, 3'd0, 15'sd0);
    slot(14'sd0, 2'd3, 1'b1, XPP, YP1, 3'd1, -15'sd128);
    slot(14'sd0, 2'd3, 1'b1, XPP, YP1, 3'd7, -15'sd8191);
    slot(14'sd0, 2'd3, 1'b1, XPP, YP1, 3'd2, -15'sd256);

    // full-scale sums without wrap
    sec = 6; idx = 0;
    for (int k = 0; k < 12; k++) slot(14'sd8191, 2'd3, 1'b0, 3'b000, 3'b000, 3'd0, 15'sd0);
    slot(14'sd8191, 2'd3, 1'b0, XPP, YP1, 3'd0, 15'sd16382);
    for (int k = 0; k < 12; k++) slot(-14'sd8192, 2'd3, 1'b0, 3'b000, 3'b000, 3'd0, 15'sd0);
    slot(14'sd0, 2'd3, 1'b0, XPP, YP1, 3'd0, -15'sd16384);

    // internal lines, mixed sources, then select over-use and priority
    sec = 7; idx = 0;
    for (int k = 0; k < 27; k++) begin
      logic signed [W-1:0] r;
      logic [1:0] id;
      logic [2:0] xs, ys;
      logic signed [W:0] em;
      r = '0; id = 2'd3; xs = 3'b000; ys = 3'b000; em = '0;
      case (k)
        0:  begin r = 14'sd1000; id = 2'd0; end
        1:  begin r = -14'sd300; id = 2'd1; end
        2:  begin r = 14'sd50;   id = 2'd2; end
        6:  begin xs = XIN; em = 15'sd1000; end
        7:  begin ys = YIN; em = -15'sd300; end
        8:  begin r = 14'sd7; id = 2'd0; ys = YP2; em = 15'sd50; end
        12: begin xs = XIN; em = 15'sd1000; end
        13: begin ys = YIN; em = -15'sd300; end
        14: begin xs = XP2; ys = YP2; em = 15'sd100; end
        18: begin xs = XIN; ys = YP1; em = 15'sd1000; end
        19: begin ys = YIN; em = -15'sd300; end
        20: begin xs = XP2 | XIN; em = 15'sd50; end
        24: begin xs = XPP | XIN; em = 15'sd0; end
        25: begin ys = YP2 | YIN; em = 15'sd0; end
        26: begin xs = XIN; ys = YP2; em = 15'sd57; end
        default: ;
      endcase
      slot(r, id, 1'b0, xs, ys, 3'd0, em);
    end

    // reset clears the sticky error; all selects on with empty history
    reset_check("overuse");
    sec = 8; idx = 0;
    slot(14'sd0, 2'd3, 1'b0, 3'b111, 3'b111, 3'd0, 15'sd0);
    slot(14'sd0, 2'd3, 1'b1, 3'b111, 3'b111, 3'd0, 15'sd0);

    reset_check("final");
    sec = 9; idx = 0;
    slot(14'sd0, 2'd3, 1'b0, 3'b000, 3'b000, 3'd0, 15'sd0);

    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_now("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
